dht11: RTL and testbench



---
 rtl/dht11.sv | 142 ++++++++++++++
 tb/tb_dht11.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/dht11.sv
// dht11 -- passive receiver for the DHT11 single-wire sensor protocol.
//
// Watches the sensor data line and measures each high pulse in clock cycles.
// From those widths it recognises the sensor response preamble and then
// decodes a 40-bit frame, MSB first. If the checksum byte matches the low
// byte of the sum of the other four bytes, the frame is latched on data.
// The line is never driven from here.
//
// Ports:
//   clk         system clock, nominally 100 kHz
//   rst         synchronous active-high reset
//   dht11_data  sensor data line (asynchronous, idle high)
//   data        last good frame: {hum_int, hum_dec, temp_int, temp_dec, checksum}
module dht11 #(
  parameter int THRESH_CYCLES  = 5,
  parameter int RESP_HIGH_MIN  = 6,
  parameter int TIMEOUT_CYCLES = 20,
  parameter int CNT_W          = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        dht11_data,
  output logic [39:0] data
);

  typedef enum logic [2:0] {
    IDLE,
    SYNC_LOW,
    SYNC_HIGH,
    BIT_LOW,
    BIT_HIGH,
    CHECK
  } state_t;

  localparam logic [CNT_W:0]   THRESH_LEN  = (CNT_W+1)'(THRESH_CYCLES);
  localparam logic [CNT_W:0]   RESP_LEN    = (CNT_W+1)'(RESP_HIGH_MIN);
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT_CYCLES);

  state_t           state, state_n;
  logic             sync_p0, s, s_d;
  logic [CNT_W-1:0] cnt;
  logic [5:0]       bit_cnt;
  logic [39:0]      shreg;
  logic             fall, rise, timeout;
  logic             shift_en, clr_bits, load;

  // The counter is cleared in the clock after an edge is seen, so at the
  // terminating edge it holds (pulse width - 1). Compare on the full width.
  function automatic logic width_at_least(input logic [CNT_W-1:0] c,
                                          input logic [CNT_W:0]   min_len);
    logic [CNT_W:0] len;
    len = {1'b0, c} + {{CNT_W{1'b0}}, 1'b1};
    return len >= min_len;
  endfunction

  function automatic logic checksum_ok(input logic [39:0] f);
    logic [7:0] sum;
    sum = f[39:32] + f[31:24] + f[23:16] + f[15:8];
    return sum == f[7:0];
  endfunction

  assign fall    = s_d & ~s;
  assign rise    = ~s_d & s;
  assign timeout = (cnt >= TIMEOUT_CNT);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n  = state;
    shift_en = 1'b0;
    clr_bits = 1'b0;
    load     = 1'b0;
    case (state)
      IDLE:      if (fall) state_n = SYNC_LOW;
      // No timeout here: the host start low lasts 18 ms or more.
      SYNC_LOW:  if (rise) state_n = SYNC_HIGH;
      SYNC_HIGH: begin
        if (fall) begin
          // A short high is the host releasing the line; keep waiting for
          // the sensor's long response high.
          if (width_at_least(cnt, RESP_LEN)) begin
            state_n  = BIT_LOW;
            clr_bits = 1'b1;
          end else begin
            state_n = SYNC_LOW;
          end
        end else if (timeout) begin
          state_n = IDLE;
        end
      end
      BIT_LOW: begin
        if (rise)         state_n = BIT_HIGH;
        else if (timeout) state_n = IDLE;
      end
      BIT_HIGH: begin
        if (fall) begin
          shift_en = 1'b1;
          state_n  = (bit_cnt == 6'd39) ? CHECK : BIT_LOW;
        end else if (timeout) begin
          state_n = IDLE;
        end
      end
      CHECK: begin
        load    = checksum_ok(shreg);
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      sync_p0 <= 1'b1;
      s       <= 1'b1;
      s_d     <= 1'b1;
      cnt     <= '0;
      bit_cnt <= '0;
      shreg   <= '0;
      data    <= '0;
    end else begin
      // Stage p0: first synchronizer flop; s: second flop; s_d: edge reference
      sync_p0 <= dht11_data;
      s       <= sync_p0;
      s_d     <= s;

      if (fall || rise)   cnt <= '0;
      else if (cnt != '1) cnt <= cnt + 1'b1;

      if (clr_bits) bit_cnt <= '0;
      if (shift_en) begin
        shreg   <= {shreg[38:0], width_at_least(cnt, THRESH_LEN)};
        bit_cnt <= bit_cnt + 6'd1;
      end

      if (load) data <= shreg;
    end
  end

endmodule

// File: tb/tb_dht11.sv
`timescale 1us/100ns
module tb_dht11;

  logic        clk = 1'b0;
  logic        rst;
  logic        dht11_data;
  logic [39:0] data;

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [39:0] exp_data;

  dht11 dut (
    .clk        (clk),
    .rst        (rst),
    .dht11_data (dht11_data),
    .data       (data)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [39:0] obs, input logic [39:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Reference: a frame is accepted only when its checksum byte equals the
  // sum of the four payload bytes modulo 256; otherwise data keeps its value.
  function automatic logic [39:0] model(input logic [39:0] f, input logic [39:0] prev);
    int sum;
    sum = (int'(f[39:32]) + int'(f[31:24]) + int'(f[23:16]) + int'(f[15:8])) % 256;
    return (sum == int'(f[7:0])) ? f : prev;
  endfunction

  // Hold the line at v for n clocks (changes on the falling clock edge).
  task automatic level(input logic v, input int n);
    dht11_data = v;
    repeat (n) @(negedge clk);
  endtask

  // mode 0: nominal widths, 1: randomised widths, 2: threshold-boundary widths
  task automatic send_frame(input logic [39:0] f, input int nbits,
                            input int host_low, input int mode);
    int lo, h0, h1;
    level(0, host_low);
    if (mode == 1) begin
      level(1, $urandom_range(2, 4));
      level(0, $urandom_range(6, 9));
      level(1, $urandom_range(6, 10));
    end else begin
      level(1, 3);
      level(0, 8);
      level(1, 8);
    end
    for (int i = 0; i < nbits; i++) begin
      case (mode)
        1:       begin lo = $urandom_range(3, 8); h0 = $urandom_range(1, 4); h1 = $urandom_range(5, 9); end
        2:       begin lo = 5; h0 = 4; h1 = 5; end
        default: begin lo = 5; h0 = 3; h1 = 7; end
      endcase
      level(0, lo);
      level(1, f[39-i] ? h1 : h0);
    end
  endtask

  // Trailing low after bit 40: data must not change before the 4th rising
  // clock edge after the line falls, and must hold the model value after it.
  task automatic finish_frame(input string tag, input logic [39:0] f);
    logic [39:0] prev;
    prev     = exp_data;
    exp_data = model(f, prev);
    dht11_data = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    if (exp_data !== prev) check({tag, "_early"}, data, prev);
    @(posedge clk);
    #1;
    check(tag, data, exp_data);
    @(negedge clk);
    level(0, 1);
    level(1, 30);
    check({tag, "_hold"}, data, exp_data);
  endtask

  initial begin
    logic [39:0] f;
    exp_data   = '0;
    rst        = 1'b1;
    dht11_data = 1'b1;
    repeat (3) @(negedge clk);
    check("reset", data, exp_data);
    rst = 1'b0;

    for (int i = 0; i < 4; i++) begin
      level(1, 25);
      check("idle_high", data, exp_data);
    end

    level(0, 10);
    level(1, 100);
    check("partial_preamble", data, exp_data);

    send_frame(40'h35001A004F, 40, 1800, 0);
    finish_frame("frame_a", 40'h35001A004F);

    send_frame(40'h35001A0050, 40, 1800, 0);
    finish_frame("bad_checksum", 40'h35001A0050);

    send_frame(40'h2800190041, 20, 1800, 0);
    level(1, 30);
    check("truncated", data, exp_data);

    send_frame(40'h2800190041, 40, 1800, 0);
    finish_frame("frame_b", 40'h2800190041);

    send_frame(40'hA55A0FF0FE, 40, 300, 2);
    finish_frame("boundary", 40'hA55A0FF0FE);

    for (int k = 0; k < 6; k++) begin
      f[39:8] = $urandom;
      f[7:0]  = f[39:32] + f[31:24] + f[23:16] + f[15:8];
      if ($urandom_range(0, 2) == 0) f[7:0] = f[7:0] ^ 8'($urandom_range(1, 255));
      send_frame(f, 40, $urandom_range(50, 200), 1);
      finish_frame("random", f);
    end

    // Reset during bit 25 of a valid frame
    f = 40'h2800190041;
    send_frame(f, 24, 300, 0);
    level(0, 2);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    exp_data = '0;
    #1;
    check("reset_mid", data, exp_data);
    level(0, 3);
    level(1, f[15] ? 7 : 3);
    for (int i = 25; i < 40; i++) begin
      level(0, 5);
      level(1, f[39-i] ? 7 : 3);
    end
    level(0, 5);
    level(1, 30);
    check("after_reset_tail", data, exp_data);

    send_frame(40'h35001A004F, 40, 300, 0);
    finish_frame("frame_after_reset", 40'h35001A004F);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
